// File: rtl/rgmii_to_gmii_rx.sv
// RGMII receive capture to an 8-bit GMII stream, in-band status decode and preamble/SFD framing.
// Define RGMII_RX_STATS_EN to add good/error/drop frame counters.
module rgmii_to_gmii_rx #(
    parameter int MAX_FRAME_LEN = 1522,
    parameter int LEN_W         = 16
) (
    input  logic             gmii_rx_clk,
    input  logic             reset_n,
    input  logic [3:0]       rgmii_rxd,
    input  logic             rgmii_rxctl,
    output logic [7:0]       gmii_rxd,
    output logic             gmii_rxdv,
    output logic             gmii_rxer,
    output logic [7:0]       frame_data,
    output logic             frame_valid,
    output logic             frame_sof,
    output logic             frame_eof,
    output logic             frame_err,
    output logic [LEN_W-1:0] frame_len,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             full_duplex
`ifdef RGMII_RX_STATS_EN
    ,
    output logic [31:0]      stat_good_frames,
    output logic [31:0]      stat_err_frames,
    output logic [31:0]      stat_drop_frames
`endif
);

    localparam int LANES = 5;

    typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_DROP} state_t;

    logic [LANES-1:0] pin_bus;
    logic [LANES-1:0] rise_q1;
    logic [LANES-1:0] fall_q2;
    logic             capture_ok_reg;
    logic [7:0]       iddr_byte;
    logic             iddr_dv;
    logic             iddr_er;

    assign pin_bus = {rgmii_rxctl, rgmii_rxd};

    // The falling-edge flop is never reset; capture_ok_reg blanks its output
    // for the first aligned pair after reset so pin noise cannot leak through.
    always_ff @(posedge gmii_rx_clk) begin
        if (!reset_n) capture_ok_reg <= 1'b0;
        else          capture_ok_reg <= 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_iddr
            logic rise_reg, fall_reg, q1_reg, q2_reg;
            always_ff @(negedge gmii_rx_clk) fall_reg <= pin_bus[gi];
            always_ff @(posedge gmii_rx_clk) begin
                if (!reset_n) begin
                    rise_reg <= 1'b0;
                    q1_reg   <= 1'b0;
                    q2_reg   <= 1'b0;
                end else begin
                    rise_reg <= pin_bus[gi];
                    q1_reg   <= rise_reg;
                    q2_reg   <= capture_ok_reg ? fall_reg : 1'b0;
                end
            end
            assign rise_q1[gi] = q1_reg;
            assign fall_q2[gi] = q2_reg;
        end
    endgenerate

    assign iddr_byte = {fall_q2[3:0], rise_q1[3:0]};
    assign iddr_dv   = rise_q1[4];
    assign iddr_er   = rise_q1[4] ^ fall_q2[4];

    // Status is decoded from the aligned pair, so it changes on the same edge
    // that the byte appears on gmii_rxd.
    always_ff @(posedge gmii_rx_clk) begin
        if (!reset_n) begin
            gmii_rxd    <= 8'h00;
            gmii_rxdv   <= 1'b0;
            gmii_rxer   <= 1'b0;
            link_up     <= 1'b0;
            link_speed  <= 2'b00;
            full_duplex <= 1'b0;
        end else begin
            gmii_rxd  <= iddr_byte;
            gmii_rxdv <= iddr_dv;
            gmii_rxer <= iddr_er;
            if (!iddr_dv && !iddr_er && (iddr_byte[3:0] == iddr_byte[7:4])) begin
                link_up     <= iddr_byte[0];
                full_duplex <= iddr_byte[3];
                if (iddr_byte[2:1] != 2'b11) link_speed <= iddr_byte[2:1];
            end
        end
    end

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic             err_reg, err_next;
    logic [7:0]       data_next;
    logic             valid_next, sof_next, eof_next, ferr_next;
    logic [LEN_W-1:0] len_next;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        err_next   = err_reg;
        data_next  = 8'h00;
        valid_next = 1'b0;
        sof_next   = 1'b0;
        eof_next   = 1'b0;
        ferr_next  = 1'b0;
        len_next   = '0;
        case (state_reg)
            ST_IDLE, ST_PREAMBLE: begin
                if (!gmii_rxdv) begin
                    state_next = ST_IDLE;
                end else if (gmii_rxd == 8'h55) begin
                    state_next = ST_PREAMBLE;
                end else if (gmii_rxd == 8'hD5) begin
                    state_next = ST_DATA;
                    count_next = '0;
                    err_next   = 1'b0;
                end else begin
                    state_next = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!gmii_rxdv) begin
                    eof_next   = 1'b1;
                    len_next   = count_reg;
                    ferr_next  = err_reg || (count_reg == '0);
                    state_next = ST_IDLE;
                end else begin
                    if (gmii_rxer) err_next = 1'b1;
                    // Bytes past the length limit are swallowed and mark the frame bad.
                    if (count_reg < LEN_W'(MAX_FRAME_LEN)) begin
                        valid_next = 1'b1;
                        data_next  = gmii_rxd;
                        sof_next   = (count_reg == '0);
                        count_next = count_reg + LEN_W'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!gmii_rxdv) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            err_reg     <= 1'b0;
            frame_data  <= 8'h00;
            frame_valid <= 1'b0;
            frame_sof   <= 1'b0;
            frame_eof   <= 1'b0;
            frame_err   <= 1'b0;
            frame_len   <= '0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            err_reg     <= err_next;
            frame_data  <= data_next;
            frame_valid <= valid_next;
            frame_sof   <= sof_next;
            frame_eof   <= eof_next;
            frame_err   <= ferr_next;
            frame_len   <= len_next;
        end
    end

`ifdef RGMII_RX_STATS_EN
    logic drop_entry;
    assign drop_entry = (state_reg != ST_DROP) && (state_reg != ST_DATA) && (state_next == ST_DROP);

    always_ff @(posedge gmii_rx_clk) begin
        if (!reset_n) begin
            stat_good_frames <= 32'd0;
            stat_err_frames  <= 32'd0;
            stat_drop_frames <= 32'd0;
        end else begin
            if (eof_next && !ferr_next && (stat_good_frames != 32'hFFFF_FFFF))
                stat_good_frames <= stat_good_frames + 32'd1;
            if (eof_next && ferr_next && (stat_err_frames != 32'hFFFF_FFFF))
                stat_err_frames <= stat_err_frames + 32'd1;
            if (drop_entry && (stat_drop_frames != 32'hFFFF_FFFF))
                stat_drop_frames <= stat_drop_frames + 32'd1;
        end
    end
`endif

endmodule

// File: doc/rgmii_to_gmii_rx.md
Name: rgmii_to_gmii_rx

Overview:
- Receive-side counterpart of the GMII-to-RGMII transmit path. Captures the RGMII DDR receive bus into an 8-bit GMII byte stream.
- Decodes the in-band link status sent during the inter-frame gap.
- Strips preamble/SFD and presents framed payload bytes with start, end and error markers to the downstream MAC/UDP receive logic.
- Sits directly behind the PHY pins in the 1000M receive path; one clock domain, gmii_rx_clk, sourced from the PHY's rgmii_rx_clk.

Parameters:
- MAX_FRAME_LEN, 1522, maximum payload bytes (after SFD, FCS included) accepted per frame before truncation.
- LEN_W, 16, width of the frame length counter.

Ports:
- gmii_rx_clk  input  1  receive clock; the same net as rgmii_rx_clk, used for both DDR edges.
- reset_n  input  1  reset, synchronous to gmii_rx_clk, active-low.
- rgmii_rxd  input  4  RGMII data: low nibble on rising edge, high nibble on falling edge.
- rgmii_rxctl  input  1  RGMII control: RX_DV on rising edge, RX_DV^RX_ER on falling edge.
- gmii_rxd  output  8  captured byte.
- gmii_rxdv  output  1  captured RX_DV.
- gmii_rxer  output  1  captured RX_ER (rising ctl XOR falling ctl).
- frame_data  output  8  payload byte.
- frame_valid  output  1  frame_data qualifier.
- frame_sof  output  1  first payload byte of a frame (coincides with frame_valid).
- frame_eof  output  1  one-cycle pulse the cycle after the last payload byte.
- frame_err  output  1  valid only with frame_eof; frame had an error.
- frame_len  output  LEN_W  payload byte count; valid with frame_eof.
- link_up  output  1  in-band link status.
- link_speed  output  2  in-band speed: 00=10M, 01=100M, 10=1000M.
- full_duplex  output  1  in-band duplex.

Behaviour:
- Capture:
  - One IDDR per rgmii_rxd bit and one for rgmii_rxctl.
  - Each byte is formed from a rising-edge nibble (bits 3:0) and the following falling-edge nibble (bits 7:4), then registered.
  - gmii_rxd/gmii_rxdv/gmii_rxer appear exactly 2 gmii_rx_clk cycles after the rising edge that sampled the low nibble.
- Reset (reset_n low at a rising edge):
  - All outputs go to 0, the FSM goes to IDLE, and counters clear. The in-band status registers also clear (link_up=0, link_speed=00, full_duplex=0).
  - Reset mid-frame discards the frame with no frame_eof.
- In-band status: while gmii_rxdv=0 and gmii_rxer=0, and gmii_rxd[3:0]==gmii_rxd[7:4], latch:
  - link_up=rxd[0]
  - link_speed=rxd[2:1] (code 11 is ignored; previous value kept)
  - full_duplex=rxd[3]
  - Status registers are never updated while gmii_rxdv=1.
- Frame FSM, evaluated on the captured stream:
  - IDLE: gmii_rxdv=1 and byte=0x55 -> PREAMBLE. gmii_rxdv=1 and byte=0xD5 -> DATA (SFD with no preamble is accepted). Any other byte with dv=1 -> DROP.
  - PREAMBLE: 0x55 stays. 0xD5 -> DATA. Other byte -> DROP. dv=0 -> IDLE with no eof.
  - DATA: each byte with dv=1 drives frame_valid=1 and frame_data=byte. frame_sof=1 on the first byte. Length increments.
    - gmii_rxer=1 in DATA sets a sticky error; the byte is still passed.
    - dv=0 -> frame_eof=1 for one cycle, with frame_len=count and frame_err=sticky, then -> IDLE.
    - An SFD followed immediately by dv=0 gives frame_eof with frame_len=0 and frame_err=1.
  - Truncation: when count reaches MAX_FRAME_LEN, further bytes are not presented and the sticky error is set. frame_len holds MAX_FRAME_LEN, and eof is still issued at dv fall.
  - DROP: ignore bytes until dv=0 -> IDLE; no frame outputs.
- Carrier extension/false carrier (dv=0, er=1) is not status and not a frame; it is ignored.
- Back-to-back frames: a minimum 1-cycle dv=0 gap is sufficient. eof of frame N may coincide with IDLE evaluation of the next byte.
- frame_len counter: LEN_W bits; MAX_FRAME_LEN must be < 2^LEN_W.

Optional Feature:
- RGMII_RX_STATS_EN defined: adds outputs stat_good_frames [31:0], stat_err_frames [31:0] and stat_drop_frames [31:0], all cleared on reset.
  - At frame_eof, frame_err=0 increments good and frame_err=1 increments err.
  - Each DROP entry increments drop.
  - All three saturate at 0xFFFFFFFF.
- Not defined: these ports and counters do not exist.

Test Plan:
- Reset held, random pins -> all outputs 0. Release, idle nibbles 0xD on both edges -> link_up=1, link_speed=10, full_duplex=1 two cycles later.
- 7x0x55, 0xD5, 64 bytes 0x00..0x3F, dv low -> frame_sof with data 0x00; 64 frame_valid cycles; frame_eof, frame_len=64, frame_err=0.
- Same frame with rxer pulsed on byte 10 -> all 64 bytes passed, frame_eof with frame_err=1, frame_len=64.
- Preamble 0x55,0x55,0xAA,... -> no frame_valid, no eof; stat_drop_frames=1 when RGMII_RX_STATS_EN is defined.
- 1600-byte payload -> exactly 1522 frame_valid cycles; frame_len=1522, frame_err=1.
- Reset asserted at payload byte 20 -> no frame_eof. Next clean 46-byte frame reports frame_len=46, frame_err=0. In-band status change 0xD->0x0 during dv=1 is ignored, then applied in the following gap.
